branch_tracker: RTL

- Sits between the fetch/decode front end and the 2-bit saturating branch predictor.
- For each fetched branch it raises a predictor request and returns the prediction to fetch one cycle later. It also holds the prediction in an in-order in-flight queue.
- When execute resolves the oldest branch, it drives the predictor training handshake (result/taken), detects a mispredict and flushes all younger in-flight branches.

---
 rtl/bp_pkg.sv | 15 +
 rtl/bp_fifo.sv | 63 ++++++
 rtl/branch_tracker.sv | 113 +++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch tracker: queue depth default, occupancy width
// and the per-branch in-flight record.
package bp_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int OCC_W_DEF = $clog2(DEPTH_DEF) + 1;

  typedef logic [OCC_W_DEF-1:0] occ_t;

  // One in-flight branch; room to add a PC tag alongside the direction.
  typedef struct packed {
    logic dir;
  } inflight_t;

endpackage

// File: rtl/bp_fifo.sv
// In-order queue of predicted directions; supports push and pop on the same
// edge, and a flush that discards everything at once.
module bp_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  inflight_t             push_data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output inflight_t             pop_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  inflight_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full_o     = (count_q == DEPTH_C);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A full queue can still take a push when the head leaves on the same edge.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  // NOTE: the storage array has no reset; only pointers and count say which
  // entries hold live data, so clearing the array would add nothing.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop sees
  // the pre-edge value of every other flop, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/branch_tracker.sv
// Glue between fetch/decode and a 2-bit predictor: issues prediction requests,
// tracks in-flight branches in order, trains on resolve and flushes on mispredict.
module branch_tracker
  import bp_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   br_valid,
  output logic                   br_ready,
  output logic                   pred_valid,
  output logic                   pred_dir,
  input  logic                   res_valid,
  input  logic                   res_taken,
  output logic                   mispredict,
  output logic                   request,
  output logic                   result,
  output logic                   taken,
  input  logic                   prediction,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_W-1:0]       n_resolved,
  output logic [CNT_W-1:0]       n_mispred,
  output logic                   resolve_err
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             pending_q, pending_d;
  logic             mispredict_q, mispredict_d;
  logic             resolve_err_q, resolve_err_d;
  logic [CNT_W-1:0] n_resolved_q, n_resolved_d;
  logic [CNT_W-1:0] n_mispred_q, n_mispred_d;

  logic             q_push, q_pop, q_flush, q_full, q_empty;
  logic [OCC_W-1:0] q_count;
  inflight_t        q_head, q_wdata;

  logic in_flight, cmp_dir, res_fire, res_miss, res_hit;

  bp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (q_push),
    .push_data_i(q_wdata),
    .pop_i      (q_pop),
    .flush_i    (q_flush),
    .pop_data_o (q_head),
    .count_o    (q_count),
    .full_o     (q_full),
    .empty_o    (q_empty)
  );

  // The pending slot is the youngest branch, still waiting on its prediction.
  assign occupancy = q_count + OCC_W'(pending_q);

  always_comb begin
    // NOTE: every combinational output is assigned on every path before any
    // conditional update, so no latch can be inferred.
    in_flight     = (occupancy != '0);
    cmp_dir       = q_empty ? prediction : q_head.dir;
    res_fire      = res_valid & in_flight;
    res_miss      = res_fire & (cmp_dir != res_taken);
    res_hit       = res_fire & ~res_miss;

    br_ready      = rst_n & (occupancy < FULL_OCC) & ~res_miss;
    request       = br_valid & br_ready;
    result        = rst_n & res_fire;
    taken         = rst_n & res_taken;

    q_wdata       = '{dir: prediction};
    q_flush       = res_miss;
    q_pop         = res_hit & ~q_empty;
    // On a bypass resolve the pending branch is consumed instead of queued.
    q_push        = pending_q & ~res_miss & ~(res_hit & q_empty) & (~q_full | q_pop);

    pending_d     = request;
    mispredict_d  = res_miss;
    resolve_err_d = resolve_err_q | (res_valid & ~in_flight);

    n_resolved_d  = n_resolved_q;
    n_mispred_d   = n_mispred_q;
    if (res_fire && n_resolved_q != CNT_MAX) n_resolved_d = n_resolved_q + CNT_W'(1);
    if (res_miss && n_mispred_q != CNT_MAX)  n_mispred_d  = n_mispred_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q     <= 1'b0;
      mispredict_q  <= 1'b0;
      resolve_err_q <= 1'b0;
      n_resolved_q  <= '0;
      n_mispred_q   <= '0;
    end else begin
      pending_q     <= pending_d;
      mispredict_q  <= mispredict_d;
      resolve_err_q <= resolve_err_d;
      n_resolved_q  <= n_resolved_d;
      n_mispred_q   <= n_mispred_d;
    end
  end

  assign pred_valid  = pending_q;
  assign pred_dir    = pending_q & prediction;
  assign mispredict  = mispredict_q;
  assign resolve_err = resolve_err_q;
  assign n_resolved  = n_resolved_q;
  assign n_mispred   = n_mispred_q;

endmodule
